// File: rtl/sdf_bf_stage4_if.sv
// Stream interface for the 4-delay SDF butterfly stage: stage control,
// input sample, twiddle and the registered output sample.
// The master side (upstream stage / twiddle ROM) drives the inputs; the
// slave side (the butterfly stage) drives the outputs.
interface sdf_bf_stage4_if #(
    parameter int DW = 24
);
    logic                 in_valid;
    logic signed [DW-1:0] din_r;
    logic signed [DW-1:0] din_i;
    logic [1:0]           state;
    logic signed [DW-1:0] w_r;
    logic signed [DW-1:0] w_i;
    logic                 out_valid;
    logic signed [DW-1:0] dout_r;
    logic signed [DW-1:0] dout_i;

    modport master (
        output in_valid, din_r, din_i, state, w_r, w_i,
        input  out_valid, dout_r, dout_i
    );

    modport slave (
        input  in_valid, din_r, din_i, state, w_r, w_i,
        output out_valid, dout_r, dout_i
    );
endinterface

// File: rtl/sdf_bf_stage4.sv
// Radix-2 single-path delay-feedback DIF butterfly stage, 4-entry feedback
// delay line (8-point span of the 512-point FFT pipeline).
// Stage control and twiddle come from the external 4-delay twiddle ROM; this
// block keeps no sequencing counter and simply obeys the state input.
// Optional macro SDF_ROUND_EN: when defined, twiddle products are rounded
// half-up before the right shift; otherwise they are truncated (floor).
module sdf_bf_stage4 #(
    parameter int DW    = 24,
    parameter int DEPTH = 4,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    sdf_bf_stage4_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_BFLY    = 2'd1,
        ST_TWID    = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_e;

    // Feedback delay line; index 0 is the head (oldest), DEPTH-1 the tail.
    logic signed [DW-1:0] r_dlyR [DEPTH];
    logic signed [DW-1:0] r_dlyI [DEPTH];

    state_e                 w_state;
    logic signed [DW-1:0]   w_headR;
    logic signed [DW-1:0]   w_headI;
    logic signed [DW-1:0]   w_addR;
    logic signed [DW-1:0]   w_addI;
    logic signed [DW-1:0]   w_subR;
    logic signed [DW-1:0]   w_subI;
    logic signed [2*DW-1:0] w_pRR;
    logic signed [2*DW-1:0] w_pII;
    logic signed [2*DW-1:0] w_pRI;
    logic signed [2*DW-1:0] w_pIR;
    logic signed [2*DW:0]   w_sumR;
    logic signed [2*DW:0]   w_sumI;
    logic signed [2*DW:0]   w_rndR;
    logic signed [2*DW:0]   w_rndI;
    logic signed [DW-1:0]   w_twR;
    logic signed [DW-1:0]   w_twI;
    logic                   w_push;
    logic signed [DW-1:0]   w_pushR;
    logic signed [DW-1:0]   w_pushI;

    assign w_state = state_e'(bus.state);
    assign w_headR = r_dlyR[0];
    assign w_headI = r_dlyI[0];

    // Butterfly sum/difference wrap at DW bits by design (no growth).
    assign w_addR = w_headR + bus.din_r;
    assign w_addI = w_headI + bus.din_i;
    assign w_subR = w_headR - bus.din_r;
    assign w_subI = w_headI - bus.din_i;

    // Full-precision complex multiply of the head sample by the twiddle.
    assign w_pRR  = w_headR * bus.w_r;
    assign w_pII  = w_headI * bus.w_i;
    assign w_pRI  = w_headR * bus.w_i;
    assign w_pIR  = w_headI * bus.w_r;
    assign w_sumR = (2*DW+1)'(w_pRR) - (2*DW+1)'(w_pII);
    assign w_sumI = (2*DW+1)'(w_pRI) + (2*DW+1)'(w_pIR);

`ifdef SDF_ROUND_EN
    localparam logic signed [2*DW:0] ROUND_K = (2*DW+1)'(1) <<< (FRAC-1);
    assign w_rndR = w_sumR + ROUND_K;
    assign w_rndI = w_sumI + ROUND_K;
`else
    assign w_rndR = w_sumR;
    assign w_rndI = w_sumI;
`endif

    assign w_twR = DW'(w_rndR >>> FRAC);
    assign w_twI = DW'(w_rndI >>> FRAC);

    // Select what (if anything) enters the tail of the delay line this cycle.
    always_comb begin
        w_push  = 1'b0;
        w_pushR = '0;
        w_pushI = '0;
        case (w_state)
            ST_FILL: begin
                w_push  = bus.in_valid;
                w_pushR = bus.din_r;
                w_pushI = bus.din_i;
            end
            ST_BFLY: begin
                w_push  = 1'b1;
                w_pushR = w_subR;
                w_pushI = w_subI;
            end
            ST_TWID: begin
                w_push  = 1'b1;
                w_pushR = bus.din_r;
                w_pushI = bus.din_i;
            end
            default: begin
                w_push  = 1'b0;
            end
        endcase
    end

    // Shift the delay line toward the head on every push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_dlyR[k] <= '0;
                r_dlyI[k] <= '0;
            end
        end else if (w_push) begin
            for (int k = 0; k < DEPTH-1; k++) begin
                r_dlyR[k] <= r_dlyR[k+1];
                r_dlyI[k] <= r_dlyI[k+1];
            end
            r_dlyR[DEPTH-1] <= w_pushR;
            r_dlyI[DEPTH-1] <= w_pushI;
        end
    end

    // Register the stage output; fill and illegal states hold the last sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.dout_r    <= '0;
            bus.dout_i    <= '0;
        end else begin
            case (w_state)
                ST_BFLY: begin
                    bus.out_valid <= 1'b1;
                    bus.dout_r    <= w_addR;
                    bus.dout_i    <= w_addI;
                end
                ST_TWID: begin
                    bus.out_valid <= 1'b1;
                    bus.dout_r    <= w_twR;
                    bus.dout_i    <= w_twI;
                end
                default: begin
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdf_bf_stage4.sv
// Testbench for sdf_bf_stage4: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a queue-based reference model.
module tb_sdf_bf_stage4;

    localparam int DW    = 24;
    localparam int DEPTH = 4;
    localparam int FRAC  = 8;
`ifdef SDF_ROUND_EN
    localparam longint RND = 128;
`else
    localparam longint RND = 0;
`endif

    typedef struct {
        bit     v;
        longint r;
        longint i;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    exp_t   sbQ[$];
    longint dlyR[$];
    longint dlyI[$];
    longint holdR;
    longint holdI;
    int     checks;
    int     failures;

    sdf_bf_stage4_if #(.DW(DW)) bus ();

    sdf_bf_stage4 #(.DW(DW), .DEPTH(DEPTH), .FRAC(FRAC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reduce an integer to a signed DW-bit two's-complement value.
    function automatic longint wrapDw(input longint x);
        longint m;
        m = x & ((64'sd1 <<< DW) - 1);
        if (m >= (64'sd1 <<< (DW-1)))
            m = m - (64'sd1 <<< DW);
        return m;
    endfunction

    function automatic longint randDw();
        return wrapDw(longint'($urandom));
    endfunction

    // Model state after reset: empty (zero) delay line, zero output, no pending work.
    function automatic void modelReset();
        dlyR.delete();
        dlyI.delete();
        for (int k = 0; k < DEPTH; k++) begin
            dlyR.push_back(0);
            dlyI.push_back(0);
        end
        holdR = 0;
        holdI = 0;
        sbQ.delete();
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Model push: oldest sample leaves the front, new sample joins the back.
    function automatic void modelPush(input longint r, input longint i);
        void'(dlyR.pop_front());
        void'(dlyI.pop_front());
        dlyR.push_back(r);
        dlyI.push_back(i);
    endfunction

    // Drive one cycle of inputs and queue the response the model predicts.
    task automatic applyStimulus(input int st, input bit inv,
                                 input longint dr, input longint di,
                                 input longint wr, input longint wi);
        exp_t   e;
        longint hr;
        longint hi;
        @(negedge clk);
        checkOutput("sb_pending", sbQ.size(), 0);
        bus.state    = 2'(st);
        bus.in_valid = inv;
        bus.din_r    = DW'(dr);
        bus.din_i    = DW'(di);
        bus.w_r      = DW'(wr);
        bus.w_i      = DW'(wi);
        hr = dlyR[0];
        hi = dlyI[0];
        e.v = 1'b0;
        case (st)
            0: begin
                if (inv) modelPush(dr, di);
            end
            1: begin
                e.v   = 1'b1;
                holdR = wrapDw(hr + dr);
                holdI = wrapDw(hi + di);
                modelPush(wrapDw(hr - dr), wrapDw(hi - di));
            end
            2: begin
                e.v   = 1'b1;
                holdR = wrapDw((hr * wr - hi * wi + RND) >>> FRAC);
                holdI = wrapDw((hr * wi + hi * wr + RND) >>> FRAC);
                modelPush(dr, di);
            end
            default: begin
            end
        endcase
        e.r = holdR;
        e.i = holdI;
        sbQ.push_back(e);
    endtask

    // Assert reset with random inputs, check cleared outputs, then release.
    task automatic doReset();
        @(negedge clk);
        rst_n        = 1'b0;
        bus.state    = 2'($urandom_range(0, 3));
        bus.in_valid = 1'($urandom);
        bus.din_r    = DW'(randDw());
        bus.din_i    = DW'(randDw());
        bus.w_r      = DW'(randDw());
        bus.w_i      = DW'(randDw());
        modelReset();
        #1;
        checkOutput("rst_valid", bus.out_valid, 0);
        checkOutput("rst_dout_r", bus.dout_r, 0);
        checkOutput("rst_dout_i", bus.dout_i, 0);
        repeat (2) @(negedge clk);
        bus.state    = 2'd0;
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
    endtask

    // Monitor: after each edge, compare the registered output with the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n === 1'b1 && sbQ.size() > 0) begin
                e = sbQ.pop_front();
                checkOutput("out_valid", bus.out_valid, e.v);
                checkOutput("dout_r", bus.dout_r, e.r);
                checkOutput("dout_i", bus.dout_i, e.i);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int twR[4];
        int twI[4];
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        bus.state = 2'd3;
        bus.in_valid = 1'b0;
        bus.din_r = '0; bus.din_i = '0; bus.w_r = '0; bus.w_i = '0;
        modelReset();

        // Reset, then idle fill cycles with nothing valid.
        doReset();
        repeat (3) applyStimulus(0, 1'b0, 0, 0, 0, 0);

        // Fill, butterfly and twiddle with the reference values.
        for (int k = 0; k < 4; k++) applyStimulus(0, 1'b1, 256 * (k + 1), 0, 0, 0);
        for (int k = 0; k < 4; k++) applyStimulus(1, 1'($urandom), 256, 0, 0, 0);
        twR = '{256, 181, 0, -181};
        twI = '{0, -181, -256, -181};
        for (int k = 0; k < 4; k++) applyStimulus(2, 1'($urandom), 0, 0, twR[k], twI[k]);

        // Wrap of the butterfly sum at the positive limit.
        doReset();
        for (int k = 0; k < 4; k++) applyStimulus(0, 1'b1, 8388607, -8388608, 0, 0);
        for (int k = 0; k < 4; k++) applyStimulus(1, 1'b1, 1, -1, 0, 0);
        for (int k = 0; k < 4; k++) applyStimulus(2, 1'b1, 0, 0, randDw(), randDw());

        // Small product just below one LSB: truncated or rounded.
        doReset();
        for (int k = 0; k < 4; k++) applyStimulus(0, 1'b1, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) applyStimulus(1, 1'b1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) applyStimulus(2, 1'b1, 0, 0, 181, 0);

        // Reset in the middle of the twiddle phase; afterwards head is zero.
        for (int k = 0; k < 4; k++) applyStimulus(0, 1'b1, randDw(), randDw(), 0, 0);
        for (int k = 0; k < 4; k++) applyStimulus(1, 1'b1, randDw(), randDw(), 0, 0);
        for (int k = 0; k < 2; k++) applyStimulus(2, 1'b1, randDw(), randDw(), randDw(), randDw());
        doReset();
        for (int k = 0; k < 4; k++) applyStimulus(1, 1'b1, randDw(), randDw(), 0, 0);
        for (int k = 0; k < 4; k++) applyStimulus(2, 1'b1, 0, 0, 256, 0);

        // Randomized frames with occasional gaps and illegal-state cycles.
        for (int f = 0; f < 30; f++) begin
            for (int k = 0; k < 4; k++)
                applyStimulus(0, ($urandom_range(0, 5) != 0), randDw(), randDw(), randDw(), randDw());
            if ($urandom_range(0, 3) == 0)
                applyStimulus(3, 1'($urandom), randDw(), randDw(), randDw(), randDw());
            for (int blk = 0; blk < 6; blk++) begin
                for (int k = 0; k < 4; k++) begin
                    if (blk % 2 == 0)
                        applyStimulus(1, 1'($urandom), randDw(), randDw(), 0, 0);
                    else if (f % 2 == 0)
                        applyStimulus(2, 1'($urandom), randDw(), randDw(),
                                      longint'($urandom_range(0, 512)) - 256,
                                      longint'($urandom_range(0, 512)) - 256);
                    else
                        applyStimulus(2, 1'($urandom), randDw(), randDw(), randDw(), randDw());
                end
            end
            for (int k = 0; k < 4; k++) applyStimulus(2, 1'b0, 0, 0, randDw(), randDw());
        end

        repeat (2) @(negedge clk);
        checkOutput("sb_final", sbQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdf_bf_stage4.md
Name: sdf_bf_stage4

Overview:
Radix-2 single-path delay-feedback (SDF) DIF butterfly stage with a 4-entry feedback delay line, serving the 8-point-span stage of the 512-point FFT pipeline. Consumes the 2-bit stage control and the complex twiddle (Q.8, 256 = 1.0) driven by the 4-delay twiddle ROM in the same cycle. Produces one complex sample per cycle after the fill phase. Output goes to the next (2-delay) stage.

Parameters:
DW, 24, signed data width of real/imag parts (also the twiddle width)
DEPTH, 4, feedback delay-line length in samples
FRAC, 8, twiddle fractional bits; product right-shift amount

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  din valid; only gates delay-line shifting in state 0
din_r  input  DW  input sample real, signed
din_i  input  DW  input sample imag, signed
state  input  2  0 = fill, 1 = butterfly, 2 = twiddle-multiply, 3 = illegal
w_r  input  DW  twiddle real, signed Q.FRAC, valid in state 2
w_i  input  DW  twiddle imag, signed Q.FRAC, valid in state 2
out_valid  output  1  dout valid, registered
dout_r  output  DW  output real, registered, signed
dout_i  output  DW  output imag, registered, signed

Behaviour:
- Reset (async, rst_n=0): all DEPTH delay entries, dout_r, dout_i = 0; out_valid = 0. Reset mid-stream discards all stored samples. First post-reset edge behaves as a cold start.
- Delay line: complex DW-bit shift register. head = oldest entry (pushed DEPTH shifts earlier). A push shifts by one and writes the tail.
- All input-to-output paths have 1-cycle latency. Outputs update on the clk edge from the same-cycle state, din, w and head.
- state 0: if in_valid, push din. out_valid <= 0. dout holds its previous value.
- state 1 (butterfly): a = head, b = din.
  - dout <= a + b.
  - Push a - b.
  - out_valid <= 1.
  - Shifts every cycle regardless of in_valid; the upstream stream must be continuous after fill.
- state 2 (twiddle):
  - dout_r <= (head_r*w_r - head_i*w_i) >>> FRAC.
  - dout_i <= (head_r*w_i + head_i*w_r) >>> FRAC.
  - Push din. out_valid <= 1. Shifts every cycle.
- state 3: no push. out_valid <= 0. dout holds.
- Arithmetic:
  - Add/sub are DW-bit two's-complement with wrap, no growth or saturation.
  - Products use full 2*DW-bit signed multiply; the difference/sum is formed at 2*DW+1 bits.
  - Arithmetic right shift by FRAC (floor); keep the low DW bits.
- Sequencing: the ROM gives a DEPTH-cycle state 0 fill, then alternates DEPTH cycles of state 1 and DEPTH cycles of state 2 indefinitely. This block holds no counter of its own and trusts state.
- Flush: after input ends, state 2 cycles still drain the delay line. din during drain is don't-care; the bench drives 0.

Optional Feature:
Macro SDF_ROUND_EN.
- Defined: state-2 products are rounded half-up by adding 1<<(FRAC-1) to each 2*DW+1-bit sum before the >>> FRAC.
- Undefined: truncation (floor) as above.
- Add/sub paths are unaffected either way.

Test Plan:
1. Reset: rst_n=0 with arbitrary inputs -> out_valid=0, dout_r=dout_i=0. Release, drive state=0, in_valid=0 for 3 cycles -> no push, out_valid stays 0.
2. Fill + butterfly: state 0 with din_r=256,512,768,1024 (imag 0), then state 1 with din_r=256 x4 -> out_valid=1 one cycle later; dout_r=512,768,1024,1280; dout_i=0.
3. Twiddle: continue with state 2, w = (256,0),(181,-181),(0,-256),(-181,-181), din=0 -> dout = (0,0),(181,-181),(0,-512),(-543,-543).
4. Wrap: fill with 8388607, butterfly with din_r=1 -> dout_r=-8388608 (24-bit wrap), no saturation.
5. Rounding: head=(1,0), w=(181,0) in state 2 -> dout_r=0 without SDF_ROUND_EN, 1 with it.
6. Reset mid-operation: assert rst_n during state 2 -> out_valid=0 and dout=0 immediately. After release, the state-1 butterfly outputs equal din only (head=0).
